// File: rtl/seq_shift_unit_if.sv
// Handshake and data bundle for seq_shift_unit: request side (start/operand/mode)
// and completion side (result/bit_out/busy/done).
interface seq_shift_unit_if #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
);
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] d_in;
    logic [AMT_W-1:0] amt;
    logic [1:0]       mode;
    logic             fill_in;
    logic [WIDTH-1:0] result;
    logic             bit_out;
    logic             busy;
    logic             done;

    modport master (
        output start_valid, d_in, amt, mode, fill_in,
        input  start_ready, result, bit_out, busy, done
    );

    modport slave (
        input  start_valid, d_in, amt, mode, fill_in,
        output start_ready, result, bit_out, busy, done
    );
endinterface

// File: rtl/seq_shift_unit.sv
// Sequential shifter: one single-bit LSL/LSR/ASR/ROR step per clock, amt steps per request.
// Define SEQ_SHIFT_ROTATE_EN to enable ROR on mode 11; otherwise mode 11 behaves as LSR.
module seq_shift_unit #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
) (
    input  logic          clk,
    input  logic          rst,
    seq_shift_unit_if.slave bus
);

    localparam logic [1:0] MODE_LSL = 2'b00;
    localparam logic [1:0] MODE_ASR = 2'b10;
`ifdef SEQ_SHIFT_ROTATE_EN
    localparam logic [1:0] MODE_ROR = 2'b11;
`endif

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_result;
    logic             r_bit_out;
    logic [AMT_W-1:0] r_cnt;
    logic [1:0]       r_mode;
    logic [WIDTH:0]   w_step;
    logic             w_accept;

    // Returns {bit shifted out, new value}; mode 11 falls to LSR unless rotate is built in.
    function automatic logic [WIDTH:0] shift_step(
        input logic [WIDTH-1:0] v,
        input logic [1:0]       m,
        input logic             fill
    );
        logic [WIDTH:0] s;
        case (m)
            MODE_LSL: s = {v[WIDTH-1], v[WIDTH-2:0], fill};
            MODE_ASR: s = {v[0], v[WIDTH-1], v[WIDTH-1:1]};
`ifdef SEQ_SHIFT_ROTATE_EN
            MODE_ROR: s = {v[0], v[0], v[WIDTH-1:1]};
`endif
            default:  s = {v[0], fill, v[WIDTH-1:1]};
        endcase
        return s;
    endfunction

    assign w_step   = shift_step(r_result, r_mode, bus.fill_in);
    assign w_accept = (r_state == IDLE) && bus.start_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state    = r_state;
        bus.start_ready = 1'b0;
        bus.busy        = 1'b0;
        bus.done        = 1'b0;
        case (r_state)
            IDLE: begin
                bus.start_ready = 1'b1;
                if (bus.start_valid) begin
                    w_next_state = (bus.amt != '0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                bus.busy = 1'b1;
                if (r_cnt == AMT_W'(1)) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                bus.busy     = 1'b1;
                bus.done     = 1'b1;
                w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Operand registers: loaded on acceptance, stepped in SHIFT, held otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_result  <= '0;
            r_bit_out <= 1'b0;
            r_cnt     <= '0;
            r_mode    <= '0;
        end else if (w_accept) begin
            r_result  <= bus.d_in;
            r_bit_out <= 1'b0;
            r_cnt     <= bus.amt;
            r_mode    <= bus.mode;
        end else if (r_state == SHIFT) begin
            r_result  <= w_step[WIDTH-1:0];
            r_bit_out <= w_step[WIDTH];
            r_cnt     <= r_cnt - AMT_W'(1);
        end
    end

    assign bus.result  = r_result;
    assign bus.bit_out = r_bit_out;

endmodule

// File: doc/seq_shift_unit.md
SEQ_SHIFT_UNIT -- requirements
Module: seq_shift_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning operand/result width in bits (WIDTH >= 2).
REQ-002 The block SHALL have parameter AMT_W, default 3, meaning shift-amount width; amounts 0..2^AMT_W-1 are legal, including amounts >= WIDTH.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have port start_valid, input, 1, meaning the request is present.
REQ-006 The block SHALL have port start_ready, output, 1, meaning the block can accept a request.
REQ-007 The block SHALL have port d_in, input, WIDTH, meaning the operand.
REQ-008 The block SHALL have port amt, input, AMT_W, meaning the number of single-bit shift steps.
REQ-009 The block SHALL have port mode, input, 2, with encoding 00 LSL, 01 LSR, 10 ASR, 11 ROR.
REQ-010 The block SHALL have port fill_in, input, 1, meaning the serial bit entering the vacated position for LSL/LSR, sampled on every shift step.
REQ-011 The block SHALL have port result, output, WIDTH, meaning the shifted value.
REQ-012 The block SHALL have port bit_out, output, 1, meaning the last bit shifted or rotated out.
REQ-013 The block SHALL have port busy, output, 1, high in states SHIFT and DONE.
REQ-014 The block SHALL have port done, output, 1, a one-cycle pulse marking result/bit_out valid.

Function
REQ-015 The FSM SHALL have states IDLE, SHIFT and DONE; start_ready SHALL be 1 only in IDLE.
REQ-016 Acceptance SHALL occur on an edge with start_valid=1 and start_ready=1; on acceptance the block SHALL capture d_in into result, amt into a counter and mode into a register, clear bit_out to 0, and go to SHIFT if amt!=0, else to DONE.
REQ-017 Each edge in SHIFT SHALL perform exactly one step on result and decrement the counter; the edge on which the counter equals 1 SHALL move the FSM to DONE.
REQ-018 For LSL, each step SHALL set result to {result[WIDTH-2:0], fill_in} and bit_out to the old result[WIDTH-1].
REQ-019 For LSR, each step SHALL set result to {fill_in, result[WIDTH-1:1]} and bit_out to the old result[0].
REQ-020 For ASR, each step SHALL set result to {result[WIDTH-1], result[WIDTH-1:1]} and bit_out to the old result[0]; fill_in SHALL be ignored.
REQ-021 For ROR, each step SHALL set result to {result[0], result[WIDTH-1:1]} and bit_out to the old result[0].
REQ-022 In DONE, done SHALL be 1 for exactly one cycle and the next edge SHALL return the FSM to IDLE; done SHALL rise amt+1 cycles after the accepting edge (1 cycle when amt=0).
REQ-023 Amounts >= WIDTH SHALL be executed step by step with no saturation; LSL/LSR results are then all fill_in bits, and ROR wraps modulo WIDTH.
REQ-024 result and bit_out SHALL hold their values from DONE until the next acceptance; start_valid in SHIFT/DONE SHALL be ignored, with no queueing.
REQ-025 d_in, amt and mode changing after acceptance SHALL NOT affect the operation in progress.

Reset
REQ-026 With rst=1 at an edge, the block SHALL enter IDLE and set result=0, bit_out=0, done=0 and busy=0, with start_ready=1 in the following cycle.
REQ-027 rst SHALL take priority over acceptance and over any in-progress shift; an aborted operation SHALL produce no done pulse.

Configuration
REQ-028 With macro SEQ_SHIFT_ROTATE_EN defined, mode 11 SHALL perform ROR per REQ-021.
REQ-029 Without SEQ_SHIFT_ROTATE_EN, no rotate logic SHALL be present and mode 11 SHALL execute exactly as LSR (REQ-019).

Verification (WIDTH=8, AMT_W=3)
REQ-030 LSL with d_in=8'hB5, amt=3, fill_in=0 SHALL give result=8'hA8 and bit_out=1, with done rising 4 cycles after acceptance.
REQ-031 ASR with d_in=8'h90, amt=2 SHALL give result=8'hE4 and bit_out=0.
REQ-032 LSR with d_in=8'h00, amt=7, fill_in=1 SHALL give result=8'hFE and bit_out=0.
REQ-033 ROR with d_in=8'h01, amt=1 SHALL give result=8'h80 and bit_out=1 with the macro defined, and result=8'h00 and bit_out=1 without it (fill_in=0).
REQ-034 amt=0 with d_in=8'h5A SHALL give result=8'h5A, bit_out=0 and done 1 cycle after acceptance; start_valid held high SHALL be re-accepted only in the cycle after DONE.
REQ-035 rst=1 on the 2nd SHIFT cycle of an LSL with amt=5 SHALL give IDLE, result=0, start_ready=1 and no done pulse.
